rf_loader: RTL

Stream-side controller that sits directly upstream of the 4x8 register file `memory` and drives its `addr`/`we`/`data_input` port while consuming `data_output`. It accepts bytes on a valid/ready input stream and writes them to consecutive register-file addresses, wrapping at the end. On request, it dumps the whole register file in address order onto a valid/ready output stream and flags the last word.

---
 rtl/rf_pkg.sv | 14 +
 rtl/rf_loader_if.sv | 33 +++
 rtl/memory.sv | 20 ++
 rtl/rf_loader.sv | 116 +++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the register-file loader and the register file it drives.
package rf_pkg;

   localparam int RF_DW = 8;
   localparam int RF_AW = 2;

   typedef enum logic [1:0] {
      IDLE,
      RD_START,
      RD_WAIT,
      RD_OUT
   } rf_state_e;

endpackage

// File: rtl/rf_loader_if.sv
// Byte input stream, word output stream and register-file port of rf_loader.
interface rf_loader_if #(
   parameter int DW = rf_pkg::RF_DW,
   parameter int AW = rf_pkg::RF_AW
);

   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          dump_req;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          busy;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;

   // Loader side.
   modport master (
      input  in_valid, in_data, dump_req, out_ready, mem_rdata,
      output in_ready, out_valid, out_data, out_last, busy, mem_addr, mem_we, mem_wdata
   );

   // Environment side: byte producer, word consumer and register file.
   modport slave (
      output in_valid, in_data, dump_req, out_ready, mem_rdata,
      input  in_ready, out_valid, out_data, out_last, busy, mem_addr, mem_we, mem_wdata
   );

endinterface

// File: rtl/memory.sv
// 4x8 register file: synchronous write, registered read (one cycle read latency).
module memory
   import rf_pkg::*;
(
   input  logic             clk,
   input  logic [RF_AW-1:0] addr,
   input  logic             we,
   input  logic [RF_DW-1:0] data_input,
   output logic [RF_DW-1:0] data_output
);

   logic [RF_DW-1:0] regs_q [2**RF_AW];

   // Contents deliberately have no reset; a read during a write returns the old word.
   always_ff @(posedge clk) begin
      if (we) regs_q[addr] <= data_input;
      data_output <= regs_q[addr];
   end

endmodule

// File: rtl/rf_loader.sv
// Streams bytes into consecutive register-file addresses and dumps the whole file on request.
module rf_loader
   import rf_pkg::*;
#(
   parameter int DW         = RF_DW,
   parameter int AW         = RF_AW,
   parameter int RD_LATENCY = 1
) (
   input  logic        clk,
   input  logic        rst,
   rf_loader_if.master bus
);

   localparam int            CW        = $clog2(RD_LATENCY + 2);
   localparam logic [CW-1:0] CNT_LAST  = CW'(RD_LATENCY);
   localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

   rf_state_e     state_q;
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          in_ready_q;
   logic          out_valid_q;
   logic          out_last_q;
   logic          busy_q;
   logic          mem_we_q;
   logic [AW-1:0] mem_addr_q;
   logic [DW-1:0] mem_wdata_q;
   logic [DW-1:0] out_data_q;
   logic          in_hs;

   // in_ready_q is only ever high in IDLE, so writes can only be accepted there.
   assign in_hs = bus.in_valid & in_ready_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         out_data_q  <= '0;
      end else begin
         mem_we_q <= 1'b0;
         if (in_hs) begin
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wr_ptr_q;
            mem_wdata_q <= bus.in_data;
            wr_ptr_q    <= wr_ptr_q + 1'b1;
         end

         case (state_q)
            IDLE: begin
               in_ready_q <= ~bus.dump_req;
               busy_q     <= bus.dump_req;
               if (bus.dump_req) state_q <= RD_START;
            end

            // A byte accepted together with dump_req is written during this cycle,
            // so the read address is only presented from the next edge on.
            RD_START: begin
               mem_addr_q <= rd_ptr_q;
               cnt_q      <= '0;
               state_q    <= RD_WAIT;
            end

            RD_WAIT: begin
               if (cnt_q == CNT_LAST) begin
                  out_data_q  <= bus.mem_rdata;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (rd_ptr_q == LAST_ADDR);
                  state_q     <= RD_OUT;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            RD_OUT: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  out_last_q  <= 1'b0;
                  if (out_last_q) begin
                     rd_ptr_q   <= '0;
                     busy_q     <= 1'b0;
                     in_ready_q <= 1'b1;
                     state_q    <= IDLE;
                  end else begin
                     rd_ptr_q   <= rd_ptr_q + 1'b1;
                     mem_addr_q <= rd_ptr_q + 1'b1;
                     cnt_q      <= '0;
                     state_q    <= RD_WAIT;
                  end
               end
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign bus.busy      = busy_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_wdata = mem_wdata_q;

endmodule
